ps2_kbd_rx: RTL and testbench

- Parametrised PS/2 keyboard receiver. Synchronises ps2k_clk/ps2k_data, frames 11-bit packets with parity, stop and timeout checks, and decodes E0/F0 prefixes into make/break events.
- Events are queued in a FWFT FIFO with a valid/ready handshake toward the consumer logic (display driver, UART bridge).

---
 rtl/ps2_kbd_rx.sv | 250 +++++++++++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver with E0/F0 decoding and FWFT event FIFO.
// Define PS2_ASCII_EN to add the evt_ascii lookup of the FIFO head.
module ps2_kbd_rx #(
    parameter int SYNC_STAGES = 3,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ps2k_clk,
    input  logic                          ps2k_data,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_break,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic                          frame_err
`ifdef PS2_ASCII_EN
    ,
    output logic [7:0]                    evt_ascii
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] ck_sync_q;
    logic [SYNC_STAGES-1:0] dt_sync_q;
    logic                   fall;
    logic                   din;

    state_t                 state_q;
    logic [2:0]             bit_q;
    logic [7:0]             shift_q;
    logic                   par_q;
    logic [TW-1:0]          to_q;
    logic                   byte_vld_q;
    logic [7:0]             byte_q;
    logic                   err_q;

    logic                   ext_q;
    logic                   brk_q;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   wr_en;
    logic [9:0]             mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_q;
    logic [AW-1:0]          rd_q;
    logic [CW-1:0]          cnt_q;
    logic                   ovf_q;
    logic [9:0]             head;

    // Shift both raw pins through their synchroniser chains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ck_sync_q <= '0;
            dt_sync_q <= '0;
        end else begin
            ck_sync_q <= {ck_sync_q[SYNC_STAGES-2:0], ps2k_clk};
            dt_sync_q <= {dt_sync_q[SYNC_STAGES-2:0], ps2k_data};
        end
    end

    assign fall = ck_sync_q[SYNC_STAGES-1] & ~ck_sync_q[SYNC_STAGES-2];
    assign din  = dt_sync_q[SYNC_STAGES-1];

    // Frame FSM: start/data/parity/stop on each fall, abort on timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bit_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            to_q       <= '0;
            byte_vld_q <= 1'b0;
            byte_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            byte_vld_q <= 1'b0;
            err_q      <= 1'b0;
            if (state_q == S_IDLE || fall) begin
                to_q <= '0;
            end else begin
                to_q <= to_q + TW'(1);
            end
            if (state_q != S_IDLE && !fall && to_q == TW'(TIMEOUT_CYC - 1)) begin
                state_q <= S_IDLE;
                err_q   <= 1'b1;
            end else if (fall) begin
                case (state_q)
                    S_IDLE: begin
                        if (!din) begin
                            state_q <= S_DATA;
                            bit_q   <= '0;
                        end
                    end
                    S_DATA: begin
                        shift_q <= {din, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= S_PAR;
                        end
                    end
                    S_PAR: begin
                        par_q   <= din;
                        state_q <= S_STOP;
                    end
                    S_STOP: begin
                        state_q <= S_IDLE;
                        if ((^{shift_q, par_q}) && din) begin
                            byte_vld_q <= 1'b1;
                            byte_q     <= shift_q;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign push  = byte_vld_q && byte_q != 8'hE0 && byte_q != 8'hF0;
    assign full  = cnt_q == CW'(FIFO_DEPTH);
    assign pop   = evt_valid && evt_ready;
    assign wr_en = push && (!full || pop);

    // Prefix flags: set by E0/F0, consumed by the next code, dropped on error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (err_q) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (byte_vld_q) begin
            if (byte_q == 8'hE0) begin
                ext_q <= 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_q <= 1'b1;
            end else begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end
    end

    // Event FIFO storage, pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_q] <= {ext_q, brk_q, byte_q};
                wr_q        <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            if (wr_en && !pop) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (!wr_en && pop) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (push && !wr_en) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign head       = mem_q[rd_q];
    assign evt_valid  = cnt_q != '0;
    assign evt_code   = evt_valid ? head[7:0] : 8'h00;
    assign evt_break  = evt_valid & head[8];
    assign evt_ext    = evt_valid & head[9];
    assign fifo_count = cnt_q;
    assign overflow   = ovf_q;
    assign frame_err  = err_q;

`ifdef PS2_ASCII_EN
    // Set-1-free scan code to ASCII map of the head; extended codes map to 0
    always_comb begin
        evt_ascii = 8'h00;
        if (!evt_ext) begin
            case (evt_code)
                8'h1C: evt_ascii = 8'h41;
                8'h32: evt_ascii = 8'h42;
                8'h21: evt_ascii = 8'h43;
                8'h23: evt_ascii = 8'h44;
                8'h24: evt_ascii = 8'h45;
                8'h2B: evt_ascii = 8'h46;
                8'h34: evt_ascii = 8'h47;
                8'h33: evt_ascii = 8'h48;
                8'h43: evt_ascii = 8'h49;
                8'h3B: evt_ascii = 8'h4A;
                8'h42: evt_ascii = 8'h4B;
                8'h4B: evt_ascii = 8'h4C;
                8'h3A: evt_ascii = 8'h4D;
                8'h31: evt_ascii = 8'h4E;
                8'h44: evt_ascii = 8'h4F;
                8'h4D: evt_ascii = 8'h50;
                8'h15: evt_ascii = 8'h51;
                8'h2D: evt_ascii = 8'h52;
                8'h1B: evt_ascii = 8'h53;
                8'h2C: evt_ascii = 8'h54;
                8'h3C: evt_ascii = 8'h55;
                8'h2A: evt_ascii = 8'h56;
                8'h1D: evt_ascii = 8'h57;
                8'h22: evt_ascii = 8'h58;
                8'h35: evt_ascii = 8'h59;
                8'h1A: evt_ascii = 8'h5A;
                8'h45: evt_ascii = 8'h30;
                8'h16: evt_ascii = 8'h31;
                8'h1E: evt_ascii = 8'h32;
                8'h26: evt_ascii = 8'h33;
                8'h25: evt_ascii = 8'h34;
                8'h2E: evt_ascii = 8'h35;
                8'h36: evt_ascii = 8'h36;
                8'h3D: evt_ascii = 8'h37;
                8'h3E: evt_ascii = 8'h38;
                8'h46: evt_ascii = 8'h39;
                8'h29: evt_ascii = 8'h20;
                8'h5A: evt_ascii = 8'h0D;
                default: evt_ascii = 8'h00;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: randomized PS/2 frames against a queue-based event model.
// Optional PS2_ASCII_EN also checks evt_ascii.
module tb_ps2_kbd_rx;

    localparam int S = 3;
    localparam int D = 8;
    localparam int T = 200;
    localparam int H = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2k_clk = 1'b1;
    logic       ps2k_data = 1'b1;
    logic       evt_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       frame_err;
`ifdef PS2_ASCII_EN
    logic [7:0] evt_ascii;
`endif

    ps2_kbd_rx #(
        .SYNC_STAGES (S),
        .FIFO_DEPTH  (D),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2k_clk   (ps2k_clk),
        .ps2k_data  (ps2k_data),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_ext    (evt_ext),
        .evt_break  (evt_break),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .frame_err  (frame_err)
`ifdef PS2_ASCII_EN
        ,
        .evt_ascii  (evt_ascii)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [9:0] e;
    } push_t;

    push_t      push_q[$];
    int         err_q[$];
    logic [9:0] mq[$];

    int   checks = 0;
    int   fails = 0;
    logic m_ovf = 1'b0;
    logic m_ext = 1'b0;
    logic m_brk = 1'b0;
    logic pv = 1'b0;
    logic prev_ready = 1'b0;
    logic prev_clr = 1'b0;
    logic was_valid = 1'b0;
    int   ready_mode = 1;
    logic clr_req = 1'b0;
    int   rise_cyc = -1;
    int   last_stop_c = 0;
    int   err_pulses = 0;
    int   dut_pops = 0;
    int   dut_last = 0;
    int   asc_last = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] asc(input logic [9:0] e);
        logic [7:0] let_c [26] = '{
            8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
            8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
            8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        logic [7:0] dig_c [10] = '{
            8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        if (e[9]) return 8'h00;
        for (int i = 0; i < 26; i++) if (e[7:0] == let_c[i]) return 8'(8'h41 + i);
        for (int i = 0; i < 10; i++) if (e[7:0] == dig_c[i]) return 8'(8'h30 + i);
        if (e[7:0] == 8'h29) return 8'h20;
        if (e[7:0] == 8'h5A) return 8'h0D;
        return 8'h00;
    endfunction

    // Per-cycle model update and comparison, then drive consumer inputs
    always @(negedge clk) begin
        logic drop;
        logic e_err;
        if (!rst_n) begin
            mq.delete();
            push_q.delete();
            err_q.delete();
            m_ovf = 1'b0;
            chk("rst_valid", int'(evt_valid), 0);
            chk("rst_count", int'(fifo_count), 0);
            chk("rst_ovf", int'(overflow), 0);
            chk("rst_err", int'(frame_err), 0);
            chk("rst_head", int'({evt_ext, evt_break, evt_code}), 0);
        end else begin
            if (pv && prev_ready) mq.delete(0);
            drop = 1'b0;
            while (push_q.size() > 0 && push_q[0].c <= cyc) begin
                if (push_q[0].c == cyc) begin
                    if (mq.size() < D) mq.push_back(push_q[0].e);
                    else drop = 1'b1;
                end
                push_q.delete(0);
            end
            if (drop) m_ovf = 1'b1;
            else if (prev_clr) m_ovf = 1'b0;
            e_err = 1'b0;
            while (err_q.size() > 0 && err_q[0] <= cyc) begin
                if (err_q[0] == cyc) e_err = 1'b1;
                err_q.delete(0);
            end
            chk("valid", int'(evt_valid), int'(mq.size() > 0));
            chk("count", int'(fifo_count), mq.size());
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("frame_err", int'(frame_err), int'(e_err));
            if (mq.size() > 0) begin
                chk("head", int'({evt_ext, evt_break, evt_code}), int'(mq[0]));
`ifdef PS2_ASCII_EN
                chk("ascii", int'(evt_ascii), int'(asc(mq[0])));
`endif
            end
            if (frame_err) err_pulses++;
            if (evt_valid && !was_valid) rise_cyc = cyc;
        end
        was_valid = evt_valid;
        pv = rst_n && mq.size() > 0;
        case (ready_mode)
            0: evt_ready = 1'b0;
            1: evt_ready = 1'b1;
            default: evt_ready = 1'($urandom % 2);
        endcase
        ovf_clr = clr_req;
        clr_req = 1'b0;
        prev_ready = evt_ready;
        prev_clr = ovf_clr;
        if (rst_n && evt_valid && evt_ready) begin
            dut_pops++;
            dut_last = int'({evt_ext, evt_break, evt_code});
`ifdef PS2_ASCII_EN
            asc_last = int'(evt_ascii);
`endif
        end
    end

    task automatic fall_bit(input logic b, output int c);
        ps2k_data = b;
        repeat (7) @(negedge clk);
        ps2k_clk = 1'b0;
        c = cyc;
    endtask

    task automatic rise_bit();
        repeat (H) @(negedge clk);
        ps2k_clk = 1'b1;
        repeat (H - 7) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par,
                              input logic bad_stop);
        logic [10:0] f;
        int c;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            fall_bit(f[i], c);
            if (i == 10) begin
                last_stop_c = c;
                if (bad_par || bad_stop) begin
                    err_q.push_back(c + S);
                    m_ext = 1'b0;
                    m_brk = 1'b0;
                end else if (b == 8'hE0) begin
                    m_ext = 1'b1;
                end else if (b == 8'hF0) begin
                    m_brk = 1'b1;
                end else begin
                    push_q.push_back('{c + S + 1, {m_ext, m_brk, b}});
                    m_ext = 1'b0;
                    m_brk = 1'b0;
                end
            end
            rise_bit();
        end
        ps2k_data = 1'b1;
        repeat ($urandom_range(10, 40)) @(negedge clk);
    endtask

    task automatic send_partial(input int nbits, input bit sched);
        int c;
        for (int i = 0; i <= nbits; i++) begin
            fall_bit(i == 0 ? 1'b0 : 1'($urandom % 2), c);
            if (i == nbits && sched) begin
                err_q.push_back(c + S + T);
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
            rise_bit();
        end
        ps2k_data = 1'b1;
    endtask

    initial begin
        int p0;
        int e0;
        int r;
        ready_mode = 1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);

        p0 = dut_pops;
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("lat_1C", rise_cyc - last_stop_c, 4);
        chk("evt_1C", dut_last, 'h01C);
        chk("pops_1C", dut_pops - p0, 1);
`ifdef PS2_ASCII_EN
        chk("ascii_1C", asc_last, 'h41);
`endif

        p0 = dut_pops;
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h74, 1'b0, 1'b0);
        chk("evt_E0F074", dut_last, 'h374);
        chk("pops_E0F074", dut_pops - p0, 1);
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("evt_after_pfx", dut_last, 'h01C);

        p0 = dut_pops;
        e0 = err_pulses;
        send_frame(8'h1C, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("err_pulses", err_pulses - e0, 2);
        chk("err_count", int'(fifo_count), 0);
        chk("err_pops", dut_pops - p0, 0);
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("post_err_pops", dut_pops - p0, 1);

        e0 = err_pulses;
        send_partial(4, 1'b1);
        repeat (T + 40) @(negedge clk);
        chk("timeout_err", err_pulses - e0, 1);
        send_frame(8'h32, 1'b0, 1'b0);
        chk("evt_32", dut_last, 'h032);

        ready_mode = 0;
        for (int i = 0; i < 9; i++) send_frame(8'(8'h15 + i), 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk("ovf_count", int'(fifo_count), 8);
        chk("ovf_flag", int'(overflow), 1);
        p0 = dut_pops;
        ready_mode = 1;
        repeat (20) @(negedge clk);
        chk("ovf_pops", dut_pops - p0, 8);
        chk("ovf_last", dut_last, 'h01C);
        clr_req = 1'b1;
        repeat (4) @(negedge clk);
        chk("ovf_clr", int'(overflow), 0);

        ready_mode = 0;
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'h32, 1'b0, 1'b0);
        chk("pre_rst_count", int'(fifo_count), 2);
        send_partial(4, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", int'(evt_valid), 0);
        chk("rst_mid_count", int'(fifo_count), 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        m_ext = 1'b0;
        m_brk = 1'b0;
        ready_mode = 1;
        repeat (5) @(negedge clk);
        p0 = dut_pops;
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("post_rst_pops", dut_pops - p0, 1);
        chk("post_rst_evt", dut_last, 'h01C);

        for (int n = 0; n < 40; n++) begin
            ready_mode = ($urandom % 4 == 0) ? 0 : 2;
            if ($urandom % 8 == 0) clr_req = 1'b1;
            r = $urandom % 16;
            case (r)
                0: send_frame(8'($urandom), 1'b1, 1'b0);
                1: send_frame(8'($urandom), 1'b0, 1'b1);
                2, 3: send_frame(8'hE0, 1'b0, 1'b0);
                4, 5: send_frame(8'hF0, 1'b0, 1'b0);
                15: begin
                    send_partial($urandom_range(0, 8), 1'b1);
                    repeat (T + 40) @(negedge clk);
                end
                default: send_frame(8'($urandom), 1'b0, 1'b0);
            endcase
        end
        ready_mode = 1;
        repeat (50) @(negedge clk);
        chk("drain_count", int'(fifo_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
